// File: rtl/div_pkg.sv
// Shared types and defaults for the multi-cycle DIV/DIVU sequencer.
package div_pkg;

  // Default operand/result width.
  localparam int DIV_WIDTH = 32;

  // Default quotient returned on divide-by-zero (all ones).
  localparam logic [DIV_WIDTH-1:0] DIV_DIV0_LO = {DIV_WIDTH{1'b1}};

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ITER  = 2'd2,
    FIX   = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: subtract the aligned divisor when it fits
// and shift the resulting quotient bit into q.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             ge
);

  // Compare, conditionally subtract, append the quotient bit.
  always_comb begin
    ge = (rem >= d);
    if (ge) begin
      rem_nxt = rem - d;
    end else begin
      rem_nxt = rem;
    end
    q_nxt = (q << 1'b1) | {{(WIDTH-1){1'b0}}, ge};
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: latches operand magnitudes on start, aligns
// the divisor under the dividend, iterates shift-subtract, then applies the
// quotient/remainder sign fixup. Results are held on hi/lo until the next run.
module div_ctrl
  import div_pkg::*;
#(
  parameter int               WIDTH   = DIV_WIDTH,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dva,
  input  logic [WIDTH-1:0] dvb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int KW = $clog2(WIDTH);

  div_state_t       state_r;
  div_state_t       state_s;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] q_r;
  logic [KW-1:0]    k_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             busy_s;
  logic             done_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic             accept_s;
  logic             div0_s;
  logic             small_s;
  logic             align_s;
  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_q_s;
  logic             step_ge_s;

  assign a_neg_s  = sgn & dva[WIDTH-1];
  assign b_neg_s  = sgn & dvb[WIDTH-1];
  assign abs_a_s  = a_neg_s ? -dva : dva;
  assign abs_b_s  = b_neg_s ? -dvb : dvb;
  assign accept_s = (state_r == IDLE) & start & ~flush;
  assign div0_s   = (dvb == {WIDTH{1'b0}});
  assign small_s  = (abs_a_s < abs_b_s);
  // Keep shifting while the doubled divisor still fits and cannot overflow.
  assign align_s  = ~d_r[WIDTH-1] && ((d_r << 1'b1) <= rem_r);

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_r),
    .d       (d_r),
    .q       (q_r),
    .rem_nxt (step_rem_s),
    .q_nxt   (step_q_s),
    .ge      (step_ge_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (div0_s || small_s) begin
            state_s = FIX;
          end else begin
            state_s = ALIGN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ALIGN: begin
        if (align_s) begin
          state_s = ALIGN;
        end else begin
          state_s = ITER;
        end
      end
      ITER: begin
        if (k_r == {KW{1'b0}}) begin
          state_s = FIX;
        end else begin
          state_s = ITER;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (flush) begin
      state_s = IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // Output decode, registered below so busy/done come straight from flops.
  always_comb begin
    busy_s = (state_s != IDLE);
    if ((state_r == FIX) && !flush) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // Datapath: operand capture, alignment, iteration and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r   <= {WIDTH{1'b0}};
      d_r     <= {WIDTH{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      k_r     <= {KW{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (!flush) begin
      case (state_r)
        IDLE: begin
          if (start) begin
            k_r <= {KW{1'b0}};
            d_r <= abs_b_s;
            if (div0_s) begin
              // Divide-by-zero: fixed quotient, raw dividend, no sign fixup.
              q_r     <= DIV0_LO;
              rem_r   <= dva;
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
            end else begin
              q_r     <= {WIDTH{1'b0}};
              rem_r   <= abs_a_s;
              neg_q_r <= a_neg_s ^ b_neg_s;
              neg_r_r <= a_neg_s;
            end
          end
        end
        ALIGN: begin
          if (align_s) begin
            d_r <= d_r << 1'b1;
            k_r <= k_r + KW'(1);
          end
        end
        ITER: begin
          rem_r <= step_rem_s;
          q_r   <= step_q_s;
          d_r   <= d_r >> 1'b1;
          if (k_r != {KW{1'b0}}) begin
            k_r <= k_r - KW'(1);
          end
        end
        default: begin
          rem_r <= rem_r;
        end
      endcase
    end
  end

  // Registered handshake and result outputs; results change only in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      if ((state_r == FIX) && !flush) begin
        lo_r <= neg_q_r ? -q_r : q_r;
        hi_r <= neg_r_r ? -rem_r : rem_r;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus randomized
// operands checked against an arithmetic reference model.
module tb_div_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] dva;
  logic [31:0] dvb;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;
  logic [31:0] last_lo;
  logic [31:0] last_hi;

  div_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sgn   (sgn),
    .dva   (dva),
    .dvb   (dvb),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: C-style truncating division done in 64-bit arithmetic, plus
  // the cycle count implied by the alignment distance between magnitudes.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo_e, output logic [31:0] hi_e,
                                  output int lat);
    longint sa, sb, ma, mb;
    int k;
    if (b == 32'd0) begin
      lo_e = 32'hFFFF_FFFF;
      hi_e = a;
      lat  = 1;
      return;
    end
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    lo_e = 32'(sa / sb);
    hi_e = 32'(sa % sb);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (ma < mb) begin
      lat = 1;
    end else begin
      k = 0;
      while ((mb << (k + 1)) <= ma) k++;
      lat = 2 * k + 3;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division and follow it to done, checking busy, latency, results.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input bit mid_start);
    logic [31:0] lo_e, hi_e;
    int lat, n;
    ref_div(s, a, b, lo_e, hi_e, lat);
    sgn = s; dva = a; dvb = b; start = 1'b1;
    tick();
    start = 1'b0; dva = $urandom; dvb = $urandom;
    check("busy_start", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 80) begin
      if (mid_start) begin
        start = 1'($urandom_range(0, 1));
        sgn   = 1'($urandom_range(0, 1));
        dva   = $urandom;
        dvb   = $urandom;
      end
      tick();
      n++;
      start = 1'b0;
      if (!done) check("busy_run", {31'd0, busy}, 32'd1);
    end
    check("latency", n, lat);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("lo", lo, lo_e);
    check("hi", hi, hi_e);
    last_lo = lo_e;
    last_hi = hi_e;
  endtask

  task automatic idle_cycle();
    tick();
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; dva = 32'd0; dvb = 32'd0; flush = 1'b0;
    last_lo = 32'd0; last_hi = 32'd0;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    do_div(1'b0, 32'd7, 32'd2, 1'b0);                    idle_cycle();
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);            idle_cycle();
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);    idle_cycle();
    do_div(1'b0, 32'd5, 32'd0, 1'b0);                    idle_cycle();
    do_div(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);            idle_cycle();
    do_div(1'b0, 32'd5, 32'd9, 1'b0);                    idle_cycle();
    do_div(1'b1, 32'hFFFF_FFFB, 32'd9, 1'b0);            idle_cycle();
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);            idle_cycle();
    do_div(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    // Back-to-back: next start driven in the done cycle.
    do_div(1'b0, 32'd100, 32'd7, 1'b0);
    do_div(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0);          idle_cycle();

    // Flush mid-operation: no done, results untouched.
    sgn = 1'b0; dva = 32'd7; dvb = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    repeat (8) begin
      tick();
      check("flush_nodone", {31'd0, done}, 32'd0);
    end
    check("flush_lo", lo, last_lo);
    check("flush_hi", hi, last_hi);

    // Flush and start together in IDLE: request dropped.
    dva = 32'd9; dvb = 32'd4; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("fs_busy", {31'd0, busy}, 32'd0);
    repeat (4) begin
      tick();
      check("fs_nodone", {31'd0, done}, 32'd0);
    end
    check("fs_lo", lo, last_lo);

    // Randomized operands, mixed signedness, varied alignment distance.
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) a = a >> $urandom_range(16, 31);
      do_div(s, a, b, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    // Asynchronous reset in the middle of ITER.
    sgn = 1'b0; dva = 32'hFFFF_FFFF; dvb = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (30) begin
      tick();
      check("post_rst_nodone", {31'd0, done}, 32'd0);
    end
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
